// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial mux adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mux_fa_cell.sv
// One-bit full adder whose sum and carry are each a 4:1 mux selected by {a_bit, b_bit}.
module mux_fa_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  always_comb begin
    s     = c_in;
    c_out = 1'b0;
    case ({a_bit, b_bit})
      2'b00: begin
        s     = c_in;
        c_out = 1'b0;
      end
      2'b01, 2'b10: begin
        s     = ~c_in;
        c_out = c_in;
      end
      default: begin
        s     = c_in;
        c_out = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/serial_mux_adder.sv
// Bit-serial adder/subtractor: one shared mux full-adder cell, one bit per RUN cycle,
// with a start/busy/done handshake and signed-overflow detection.
module serial_mux_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] acc_next;

  mux_fa_cell u_cell (
    .a_bit (opa[0]),
    .b_bit (opb[0]),
    .c_in  (carry),
    .s     (s_bit),
    .c_out (c_next)
  );

  // acc keeps only WIDTH-1 bits; the final bit joins it directly into sum.
  assign acc_next = {s_bit, acc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          acc   <= acc_next[WIDTH-1:1];
          carry <= c_next;
          cnt   <= cnt + 1'b1;
          // On the last bit, carry still holds the carry into the MSB.
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= c_next;
            ovf   <= carry ^ c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mux_adder.sv
// Directed bench for serial_mux_adder at WIDTH=8 with immediate-assertion checks.
module tb_serial_mux_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  serial_mux_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drives one request so the next rising edge accepts it; returns #1 after that edge.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_in,
                               input logic tcin, input logic tsub);
    a     = ta;
    b     = tb_in;
    cin   = tcin;
    sub   = tsub;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_in;
    cin   = ~tcin;
    sub   = ~tsub;
  endtask

  task automatic waitDone(output int edges, output int busy_cycles, output logic stable);
    logic [7:0] s0;
    s0          = sum;
    edges       = 0;
    busy_cycles = 0;
    stable      = 1'b1;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) busy_cycles++;
      if (sum !== s0) stable = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic runCheck(input string tag, input logic [7:0] ta, input logic [7:0] tb_in,
                          input logic tcin, input logic tsub,
                          input logic [7:0] es, input logic ec, input logic eo);
    int   n;
    int   bc;
    logic st;
    applyStimulus(ta, tb_in, tcin, tsub);
    waitDone(n, bc, st);
    checkOutput({tag, "/latency"}, n, 8);
    checkOutput({tag, "/busy_cycles"}, bc, 8);
    checkOutput({tag, "/stable"}, st, 1);
    checkOutput({tag, "/busy_at_done"}, busy, 0);
    checkOutput({tag, "/sum"}, sum, es);
    checkOutput({tag, "/cout"}, cout, ec);
    checkOutput({tag, "/ovf"}, ovf, eo);
  endtask

  task automatic doneDrops(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, "/done_width"}, done, 0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] bb;
    logic       rc;
    logic       rs;
    logic [8:0] r;
    logic       ro;
    int         n;
    int         bc;
    int         cnt;
    logic       st;

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/busy", busy, 0);
    checkOutput("reset/done", done, 0);
    checkOutput("reset/sum", sum, 0);
    checkOutput("reset/cout", cout, 0);
    checkOutput("reset/ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    runCheck("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    doneDrops("add_ff_01");
    runCheck("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    doneDrops("add_7f_01");
    runCheck("add_10_20_c", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
    doneDrops("add_10_20_c");
    runCheck("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    doneDrops("sub_05_07");
    runCheck("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    doneDrops("sub_80_01");

    // start re-pulsed during RUN must be ignored
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (n == 2 || n == 4) begin
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    checkOutput("repulse/latency", n, 8);
    checkOutput("repulse/sum", sum, 8'h46);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    checkOutput("repulse/extra_activity", cnt, 0);

    // back-to-back: request presented while in the DONE cycle
    runCheck("b2b_first", 8'h20, 8'h22, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0);
    checkOutput("b2b/done_width", done, 0);
    checkOutput("b2b/busy", busy, 1);
    waitDone(n, bc, st);
    checkOutput("b2b/latency", n, 8);
    checkOutput("b2b/sum", sum, 8'h03);
    checkOutput("b2b/stable", st, 1);
    doneDrops("b2b");

    // reset in the middle of RUN
    runCheck("pre_reset", 8'h40, 8'h41, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    doneDrops("pre_reset");
    applyStimulus(8'h55, 8'h22, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midreset/busy", busy, 0);
    checkOutput("midreset/done", done, 0);
    checkOutput("midreset/sum", sum, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) cnt++;
    end
    checkOutput("midreset/no_done", cnt, 0);
    runCheck("post_reset", 8'h55, 8'h22, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
    doneDrops("post_reset");

    // short sweep against an arithmetic reference
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      bb = rs ? ~rb : rb;
      r  = {1'b0, ra} + {1'b0, bb} + {8'h00, (rs ? 1'b1 : rc)};
      ro = (ra[7] == bb[7]) && (r[7] != ra[7]);
      runCheck("sweep", ra, rb, rc, rs, r[7:0], r[8], ro);
      doneDrops("sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
